fp_sub_seq: RTL and testbench

//  Multi-cycle IEEE-754 binary16 subtractor: result = opA - opB.

---
 rtl/fp_sub_seq.sv | 191 +++++++++++++++++++
 tb/tb_fp_sub_seq.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/fp_sub_seq.sv
// fp_sub_seq: sequential binary16 subtractor (diff = opA - opB).
// Operands are captured once and then handled one step per cycle:
// align the smaller operand, add or subtract, normalise, then round.
// Encoding 31 in the exponent field is an ordinary finite exponent.
// Any result exponent above 30 saturates to {sign, 5'h1F, 0}.
`timescale 1ns/1ps
module fp_sub_seq #(
    parameter int EXP_W     = 5,
    parameter int MAN_W     = 10,
    parameter int ALIGN_CAP = MAN_W + 3
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   opA,
    input  logic [EXP_W+MAN_W:0]   opB,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   diff,
    output logic                   busy
);

    localparam int FW = 1 + EXP_W + MAN_W;   // packed fp width
    localparam int MW = MAN_W + 4;           // hidden + stored mantissa + guard/round/sticky
    localparam int SW = MW + 1;              // plus carry bit
    localparam int EW = EXP_W + 2;           // headroom for carry and rounding increments
    localparam int KW = $clog2(ALIGN_CAP + 1);

    localparam logic [EW-1:0] E_ONE = EW'(1);
    localparam logic [EW-1:0] E_MAX = EW'((1 << EXP_W) - 2);
    localparam logic [EW-1:0] E_CAP = EW'(ALIGN_CAP);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ALIGN  = 3'd1,
        S_ADDSUB = 3'd2,
        S_NORM   = 3'd3,
        S_ROUND  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t state_q, state_d;

    logic [MW-1:0] big_q, big_d;
    logic [MW-1:0] sml_q, sml_d;
    logic [SW-1:0] sum_q, sum_d;
    logic [EW-1:0] exp_q, exp_d;
    logic          sign_q, sign_d;
    logic          add_q, add_d;
    logic [KW-1:0] k_q, k_d;
    logic [FW-1:0] diff_q, diff_d;

    // Round-half-even on guard/round/sticky, then pack to binary16.
    function automatic logic [FW-1:0] round_pack(input logic s,
                                                 input logic [EW-1:0] e,
                                                 input logic [MW-1:0] m);
        logic [MAN_W+1:0] r;
        logic [EW-1:0]    e2;
        logic             up;
        logic [FW-1:0]    res;
        up = m[2] & (m[1] | m[0] | m[3]);
        r  = {1'b0, m[MW-1:3]} + {{(MAN_W+1){1'b0}}, up};
        e2 = e;
        if (r[MAN_W+1]) begin
            r  = r >> 1;
            e2 = e + 1'b1;
        end
        if (r == '0) begin
            res = '0;
        end else if (e2 > E_MAX) begin
            res = {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (!r[MAN_W]) begin
            res = {s, {EXP_W{1'b0}}, r[MAN_W-1:0]};
        end else begin
            res = {s, e2[EXP_W-1:0], r[MAN_W-1:0]};
        end
        return res;
    endfunction

    // Operand decode: subnormals get effective exponent 1 and no hidden bit.
    logic          sA, sB;
    logic [EW-1:0] eA, eB, dexp;
    logic [MW-1:0] mA, mB;
    logic          a_big;

    assign sA    = opA[FW-1];
    assign sB    = opB[FW-1];
    assign eA    = (opA[FW-2:MAN_W] == '0) ? E_ONE : EW'(opA[FW-2:MAN_W]);
    assign eB    = (opB[FW-2:MAN_W] == '0) ? E_ONE : EW'(opB[FW-2:MAN_W]);
    assign mA    = {(opA[FW-2:MAN_W] != '0), opA[MAN_W-1:0], 3'b000};
    assign mB    = {(opB[FW-2:MAN_W] != '0), opB[MAN_W-1:0], 3'b000};
    assign a_big = {eA, mA} >= {eB, mB};
    assign dexp  = a_big ? (eA - eB) : (eB - eA);

    // Normalisation is finished when there is no carry and no further left shift applies.
    logic norm_done;
    assign norm_done = !sum_q[SW-1] && !(!sum_q[MW-1] && (exp_q > E_ONE));

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            diff_q  <= '0;
        end else begin
            state_q <= state_d;
            diff_q  <= diff_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (in_valid) state_d = S_ALIGN;
            S_ALIGN:  if (k_q == '0) state_d = S_ADDSUB;
            S_ADDSUB: state_d = S_NORM;
            S_NORM:   if (norm_done) state_d = S_ROUND;
            S_ROUND:  state_d = S_DONE;
            S_DONE:   if (out_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        in_ready  = (state_q == S_IDLE);
        busy      = (state_q != S_IDLE);
        out_valid = (state_q == S_DONE);
        diff      = diff_q;
    end

    // Datapath next-state: one alignment or normalisation shift per cycle.
    always_comb begin
        big_d  = big_q;
        sml_d  = sml_q;
        sum_d  = sum_q;
        exp_d  = exp_q;
        sign_d = sign_q;
        add_d  = add_q;
        k_d    = k_q;
        diff_d = diff_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    big_d  = a_big ? mA : mB;
                    sml_d  = a_big ? mB : mA;
                    exp_d  = a_big ? eA : eB;
                    sign_d = a_big ? sA : ~sB;
                    add_d  = sA ^ sB;
                    k_d    = (dexp > E_CAP) ? KW'(ALIGN_CAP) : dexp[KW-1:0];
                end
            end
            S_ALIGN: begin
                if (k_q != '0) begin
                    sml_d = {1'b0, sml_q[MW-1:2], sml_q[1] | sml_q[0]};
                    k_d   = k_q - 1'b1;
                end
            end
            S_ADDSUB: begin
                sum_d = add_q ? ({1'b0, big_q} + {1'b0, sml_q})
                              : ({1'b0, big_q} - {1'b0, sml_q});
            end
            S_NORM: begin
                if (sum_q[SW-1]) begin
                    sum_d = {1'b0, sum_q[SW-1:2], sum_q[1] | sum_q[0]};
                    exp_d = exp_q + 1'b1;
                end else if (!sum_q[MW-1] && (exp_q > E_ONE)) begin
                    sum_d = sum_q << 1;
                    exp_d = exp_q - 1'b1;
                end
            end
            S_ROUND: begin
                diff_d = round_pack(sign_q, exp_q, sum_q[MW-1:0]);
            end
            default: ;
        endcase
    end

    // Datapath registers; contents are only meaningful while busy.
    always_ff @(posedge clock) begin
        big_q  <= big_d;
        sml_q  <= sml_d;
        sum_q  <= sum_d;
        exp_q  <= exp_d;
        sign_q <= sign_d;
        add_q  <= add_d;
        k_q    <= k_d;
    end

endmodule

// File: tb/tb_fp_sub_seq.sv
// Directed bench for fp_sub_seq with hand-computed binary16 results.
`timescale 1ns/1ps
module tb_fp_sub_seq;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] opA = '0;
    logic [15:0] opB = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] diff;
    logic        busy;

    int n_assert = 0;
    int n_fail   = 0;

    fp_sub_seq dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opA       (opA),
        .opB       (opB),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_wait(input string tag, input int lat);
        n_assert++;
        if (lat >= 100) begin
            n_fail++;
            $error("FAIL %s: out_valid not seen within %0d cycles", tag, lat);
        end
    endtask

    // One full transaction: accept, wait for result, check, then hand it off.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp_diff, input int exp_lat,
                          input string tag);
        int lat;
        @(negedge clock);
        opA      = a;
        opB      = b;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        check({tag, "_busy"}, busy, 1'b1);
        check({tag, "_in_ready_low"}, in_ready, 1'b0);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clock);
            #1;
            lat++;
        end
        check_wait({tag, "_wait"}, lat);
        check({tag, "_out_valid"}, out_valid, 1'b1);
        check({tag, "_diff"}, diff, exp_diff);
        if (exp_lat >= 0) check({tag, "_latency"}, lat, exp_lat);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        check({tag, "_out_valid_drop"}, out_valid, 1'b0);
        check({tag, "_in_ready_back"}, in_ready, 1'b1);
    endtask

    initial begin
        int lat;
        #2;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_diff", diff, 16'h0000);
        check("rst_busy", busy, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;

        run_op(16'h3C00, 16'h3800, 16'h3800, 6,  "one_minus_half");
        run_op(16'h3C00, 16'h3C00, 16'h0000, 18, "equal_pos");
        run_op(16'hBC00, 16'hBC00, 16'h0000, 18, "equal_neg");
        run_op(16'h0000, 16'h8000, 16'h0000, -1, "pzero_minus_nzero");
        run_op(16'h8000, 16'h8000, 16'h0000, -1, "nzero_minus_nzero");
        run_op(16'h7BFF, 16'hFBFF, 16'h7C00, 5,  "overflow");
        run_op(16'h0001, 16'h0002, 16'h8001, 4,  "sub_neg");
        run_op(16'h0400, 16'h0001, 16'h03FF, 4,  "to_subnormal");
        run_op(16'h3C00, 16'h9000, 16'h3C00, 15, "tie_even_down");
        run_op(16'h3C01, 16'h9000, 16'h3C02, 15, "tie_even_up");
        run_op(16'h3C00, 16'h0001, 16'h3C00, 18, "k_capped");

        // Output held while consumer stalls; in_valid kept high must be ignored.
        @(negedge clock);
        opA      = 16'h3C00;
        opB      = 16'h3800;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        opA = 16'h4000;
        opB = 16'h3C00;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clock);
            #1;
            lat++;
        end
        check_wait("stall_wait", lat);
        check("stall_first_valid", out_valid, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            check("stall_diff", diff, 16'h3800);
            check("stall_out_valid", out_valid, 1'b1);
            check("stall_in_ready", in_ready, 1'b0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        check("stall_release_valid", out_valid, 1'b0);
        check("stall_release_ready", in_ready, 1'b1);

        // Asynchronous reset while normalising a long zero result.
        @(negedge clock);
        opA      = 16'h3C00;
        opB      = 16'h3C00;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clock);
        #3;
        check("pre_rst_busy", busy, 1'b1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_in_ready", in_ready, 1'b1);
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_diff", diff, 16'h0000);
        @(negedge clock);
        reset_n = 1'b1;
        run_op(16'h4000, 16'h3C00, 16'h3C00, 6, "after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
